// File: rtl/adc_spi_responder.sv
// adc_spi_responder: MCP3202-style SPI ADC emulator that decodes a start/SGL/ODD/MSBF command and shifts out a 12-bit sample
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_cs_n,
  input  logic        adc_sclk,
  input  logic        adc_din,
  input  logic [11:0] ch0_value,
  input  logic [11:0] ch1_value,
  output logic        adc_data_out,
  output logic        adc_data_oe,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [2:0]  last_cmd,
  output logic [11:0] sample_value
);
  typedef enum logic [2:0] {IDLE, WAIT_START, CMD, NULL_BIT, DATA_MSB, DATA_LSB, HOLD} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d, din_sync_q, din_sync_d;
  logic cs_prev_q, cs_prev_d, sclk_prev_q, sclk_prev_d;
  logic cs_s, sclk_s, din_s, cs_rise, cs_fall, sclk_rise, sclk_fall;
  logic [1:0] cmd_q, cmd_d, cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic oe_q, oe_d, dout_q, dout_d, done_q, done_d, abort_q, abort_d;
  logic [2:0] last_cmd_q, last_cmd_d;
  logic [11:0] sample_q, sample_d, pick;
  logic [12:0] diff;
  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign din_s = din_sync_q[SYNC_STAGES-1];
  assign cs_rise = cs_s & ~cs_prev_q;
  assign cs_fall = ~cs_s & cs_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // cmd_q holds {SGL, ODD} when the third command edge (MSBF) arrives
  assign diff = cmd_q[0] ? {1'b0, ch1_value} - {1'b0, ch0_value} : {1'b0, ch0_value} - {1'b0, ch1_value};
  assign pick = cmd_q[1] ? (cmd_q[0] ? ch1_value : ch0_value) : (diff[12] ? 12'h000 : diff[11:0]);
  always_comb begin
    cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], adc_cs_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], adc_sclk};
    din_sync_d = {din_sync_q[SYNC_STAGES-2:0], adc_din};
    cs_prev_d = cs_s;
    sclk_prev_d = sclk_s;
    state_d = state_q;
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    oe_d = oe_q;
    dout_d = dout_q;
    done_d = 1'b0;
    abort_d = 1'b0;
    last_cmd_d = last_cmd_q;
    sample_d = sample_q;
    if (state_q != IDLE && cs_rise) begin
      state_d = IDLE;
      oe_d = 1'b0;
      dout_d = 1'b1;
      abort_d = state_q inside {WAIT_START, CMD, NULL_BIT, DATA_MSB};
    end else begin
      case (state_q)
        IDLE: state_d = cs_fall ? WAIT_START : IDLE;
        WAIT_START: if (sclk_rise && din_s) begin
          state_d = CMD;
          cnt_d = 2'd0;
        end
        CMD: if (sclk_rise) begin
          cmd_d = {cmd_q[0], din_s};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd2) begin
            last_cmd_d = {cmd_q, din_s};
            sample_d = pick;
            state_d = NULL_BIT;
          end
        end
        NULL_BIT: if (sclk_fall) begin
          oe_d = 1'b1;
          dout_d = 1'b0;
          idx_d = 4'd11;
          state_d = DATA_MSB;
        end
        DATA_MSB: if (sclk_fall) begin
          dout_d = sample_q[idx_q];
          idx_d = idx_q - 4'd1;
          if (idx_q == 4'd0) begin
            done_d = 1'b1;
            idx_d = 4'd1;
            state_d = last_cmd_q[0] ? HOLD : DATA_LSB;
          end
        end
        DATA_LSB: if (sclk_fall) begin
          dout_d = sample_q[idx_q];
          idx_d = idx_q + 4'd1;
          state_d = (idx_q == 4'd11) ? HOLD : DATA_LSB;
        end
        HOLD: dout_d = sclk_fall ? 1'b0 : dout_q;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q <= '1;
      sclk_sync_q <= '0;
      din_sync_q <= '0;
      cs_prev_q <= 1'b1;
      sclk_prev_q <= 1'b0;
      state_q <= IDLE;
      cmd_q <= 2'b00;
      cnt_q <= 2'd0;
      idx_q <= 4'd0;
      oe_q <= 1'b0;
      dout_q <= 1'b1;
      done_q <= 1'b0;
      abort_q <= 1'b0;
      last_cmd_q <= 3'b000;
      sample_q <= 12'h000;
    end else begin
      cs_sync_q <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      din_sync_q <= din_sync_d;
      cs_prev_q <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      state_q <= state_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      oe_q <= oe_d;
      dout_q <= dout_d;
      done_q <= done_d;
      abort_q <= abort_d;
      last_cmd_q <= last_cmd_d;
      sample_q <= sample_d;
    end
  end
  assign adc_data_out = dout_q;
  assign adc_data_oe = oe_q;
  assign frame_done = done_q;
  assign frame_abort = abort_q;
  assign last_cmd = last_cmd_q;
  assign sample_value = sample_q;
endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder: directed SPI master frames against hand-computed MISO streams and status outputs
module tb_adc_spi_responder;
  localparam int H = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic adc_cs_n = 1'b1, adc_sclk = 1'b0, adc_din = 1'b0;
  logic [11:0] ch0_value = 12'h000, ch1_value = 12'h000;
  logic adc_data_out, adc_data_oe, frame_done, frame_abort;
  logic [2:0] last_cmd;
  logic [11:0] sample_value;
  int n_checks = 0, n_errors = 0;
  int done_cnt = 0, abort_cnt = 0, both_cnt = 0;
  int d0, a0;
  logic m;
  logic [31:0] rx;
  adc_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din),
    .ch0_value(ch0_value), .ch1_value(ch1_value), .adc_data_out(adc_data_out),
    .adc_data_oe(adc_data_oe), .frame_done(frame_done), .frame_abort(frame_abort),
    .last_cmd(last_cmd), .sample_value(sample_value)
  );
  always #10 clk = ~clk;
  always @(negedge clk) begin
    done_cnt += int'(frame_done);
    abort_cnt += int'(frame_abort);
    both_cnt += int'(frame_done & frame_abort);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic d, output logic b);
    adc_din = d;
    repeat (H) @(negedge clk);
    b = adc_data_out;
    adc_sclk = 1'b1;
    repeat (H) @(negedge clk);
    adc_sclk = 1'b0;
  endtask
  task automatic start_frame(input int nlead);
    logic b;
    d0 = done_cnt;
    a0 = abort_cnt;
    adc_cs_n = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nlead; i++) xfer(1'b0, b);
  endtask
  task automatic send_cmd(input logic [3:0] c);
    logic b;
    for (int i = 3; i >= 0; i--) xfer(c[i], b);
  endtask
  task automatic read_bits(input int n, output logic [31:0] r);
    logic b;
    r = '0;
    for (int i = 0; i < n; i++) begin
      xfer(1'b0, b);
      r = {r[30:0], b};
    end
  endtask
  task automatic end_frame();
    repeat (H) @(negedge clk);
    adc_cs_n = 1'b1;
    repeat (H) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_oe", {31'b0, adc_data_oe}, 0);
    check("rst_dout", {31'b0, adc_data_out}, 1);
    check("rst_cmd", {29'b0, last_cmd}, 0);
    check("rst_sample", {20'b0, sample_value}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) xfer(1'b1, m);
    repeat (H) @(negedge clk);
    check("cs_high_oe", {31'b0, adc_data_oe}, 0);
    check("cs_high_cmd", {29'b0, last_cmd}, 0);
    ch0_value = 12'hA5C;
    ch1_value = 12'hA5C;
    start_frame(0);
    send_cmd(4'b1101);
    read_bits(13, rx);
    check("se_miso", rx, {19'b0, 1'b0, 12'hA5C});
    check("se_oe", {31'b0, adc_data_oe}, 1);
    check("se_cmd", {29'b0, last_cmd}, 3'b101);
    check("se_done", done_cnt - d0, 1);
    end_frame();
    check("se_idle_oe", {31'b0, adc_data_oe}, 0);
    check("se_idle_dout", {31'b0, adc_data_out}, 1);
    check("se_no_abort", abort_cnt - a0, 0);
    ch0_value = 12'h803;
    ch1_value = 12'h000;
    start_frame(0);
    send_cmd(4'b1100);
    read_bits(26, rx);
    check("lsb_miso", rx, {6'b0, 1'b0, 12'h803, 11'b10000000001, 2'b00});
    check("lsb_cmd", {29'b0, last_cmd}, 3'b100);
    check("lsb_done", done_cnt - d0, 1);
    end_frame();
    ch0_value = 12'h100;
    ch1_value = 12'h300;
    start_frame(0);
    send_cmd(4'b1001);
    read_bits(13, rx);
    check("diff0_sample", {20'b0, sample_value}, 12'h000);
    check("diff0_miso", rx, 0);
    check("diff0_cmd", {29'b0, last_cmd}, 3'b001);
    end_frame();
    start_frame(0);
    send_cmd(4'b1011);
    ch1_value = 12'hFFF;
    read_bits(13, rx);
    check("diff1_sample", {20'b0, sample_value}, 12'h200);
    check("diff1_miso", rx, {19'b0, 1'b0, 12'h200});
    end_frame();
    ch0_value = 12'hA5C;
    ch1_value = 12'h000;
    start_frame(0);
    send_cmd(4'b1101);
    read_bits(5, rx);
    check("ab_partial", rx, 32'b01010);
    repeat (H) @(negedge clk);
    adc_cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ab_oe_hold", {31'b0, adc_data_oe}, 1);
    @(negedge clk);
    check("ab_oe_drop", {31'b0, adc_data_oe}, 0);
    check("ab_pulse", {31'b0, frame_abort}, 1);
    repeat (H) @(negedge clk);
    check("ab_count", abort_cnt - a0, 1);
    check("ab_no_done", done_cnt - d0, 0);
    start_frame(0);
    send_cmd(4'b1101);
    read_bits(13, rx);
    check("ab_next_miso", rx, {19'b0, 1'b0, 12'hA5C});
    end_frame();
    start_frame(0);
    send_cmd(4'b1101);
    read_bits(3, rx);
    repeat (H) @(negedge clk);
    adc_sclk = 1'b1;
    repeat (H) @(negedge clk);
    adc_sclk = 1'b0;
    adc_cs_n = 1'b1;
    repeat (H) @(negedge clk);
    check("sim_dout", {31'b0, adc_data_out}, 1);
    check("sim_oe", {31'b0, adc_data_oe}, 0);
    check("sim_abort", abort_cnt - a0, 1);
    ch0_value = 12'h3C5;
    start_frame(3);
    send_cmd(4'b1101);
    read_bits(13, rx);
    check("lead0_miso", rx, {19'b0, 1'b0, 12'h3C5});
    check("lead0_done", done_cnt - d0, 1);
    end_frame();
    start_frame(0);
    send_cmd(4'b1101);
    read_bits(4, rx);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_oe", {31'b0, adc_data_oe}, 0);
    check("mrst_dout", {31'b0, adc_data_out}, 1);
    check("mrst_cmd", {29'b0, last_cmd}, 0);
    check("mrst_sample", {20'b0, sample_value}, 0);
    @(negedge clk);
    rst = 1'b0;
    adc_cs_n = 1'b1;
    repeat (H) @(negedge clk);
    check("mrst_no_pulse", (abort_cnt - a0) + (done_cnt - d0), 0);
    ch1_value = 12'h0F1;
    start_frame(0);
    send_cmd(4'b1111);
    read_bits(13, rx);
    check("post_rst_miso", rx, {19'b0, 1'b0, 12'h0F1});
    check("post_rst_cmd", {29'b0, last_cmd}, 3'b111);
    end_frame();
    check("no_both", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
